// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter
//   Shares one simple-dual-port frame-buffer RAM among three read requesters
//   (VGA fetch, zoom-algorithm reader, host LOAD) and two write requesters
//   (zoom-algorithm writer, host STORE). Each requester uses a req/gnt
//   handshake. Read data comes back on the requester's own rvalid/rdata pair,
//   steered there by a tag that travels alongside the RAM read latency.
//
// Optional feature macro: STARVE_GUARD_EN
//   Defined   : ALG and HOST each have a wait counter that saturates at
//               MAX_WAIT. A requester whose counter is saturated beats VGA, and
//               vga_miss pulses in that cycle.
//   Undefined : VGA always has top read priority and vga_miss is tied to 0.
//
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   vga_/alg_/host_ req     read request; the matching addr is valid while req is high
//   vga_/alg_/host_ gnt     read accepted this cycle (combinational)
//   vga_/alg_/host_ rvalid  one-cycle pulse, the matching rdata is valid
//   alg_wr_*/host_wr_*      write request/addr/data, gnt (combinational)
//   mem_rdaddress/mem_wraddress/mem_data/mem_wren   registered RAM controls
//   mem_q                   RAM read data, valid RD_LAT edges after mem_rdaddress
//   busy                    a read is in flight or mem_wren is high
//   vga_miss                VGA was denied by the starvation guard this cycle
module frame_mem_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              alg_req,
  input  logic [ADDR_W-1:0] alg_addr,
  output logic              alg_gnt,
  output logic              alg_rvalid,
  output logic [DATA_W-1:0] alg_rdata,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              alg_wr_req,
  input  logic [ADDR_W-1:0] alg_wr_addr,
  input  logic [DATA_W-1:0] alg_wr_data,
  output logic              alg_wr_gnt,
  input  logic              host_wr_req,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_gnt,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              vga_miss
);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VGA  = 2'd1;
  localparam logic [1:0] TAG_ALG  = 2'd2;
  localparam logic [1:0] TAG_HOST = 2'd3;

  if (RD_LAT < 1 || RD_LAT > 3 || MAX_WAIT < 1) begin : g_param_check
    $error("frame_mem_arbiter: RD_LAT must be 1..3 and MAX_WAIT at least 1");
  end

  logic              vga_gnt_d, alg_gnt_d, host_gnt_d;
  logic              alg_wr_gnt_d, host_wr_gnt_d;
  logic              alg_starve, host_starve;
  logic [1:0]        tag_d;
  logic [ADDR_W-1:0] rd_addr_d;

  // Stage 0 is loaded at the grant edge. The tag in the last stage marks the
  // cycle in which mem_q carries that read's data.
  logic [1:0]        tag_q [0:RD_LAT];
  logic [RD_LAT:0]   in_flight;

  logic              rr_alg_q;   // 1: ALG wins the next ALG/HOST tie
  logic [ADDR_W-1:0] mem_rdaddress_q, mem_wraddress_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_wren_q;
  logic              vga_rvalid_q, alg_rvalid_q, host_rvalid_q;
  logic [DATA_W-1:0] vga_rdata_q, alg_rdata_q, host_rdata_q;

  // Read arbitration. Every grant is held at 0 while reset_n is low.
  always_comb begin
    vga_gnt_d  = 1'b0;
    alg_gnt_d  = 1'b0;
    host_gnt_d = 1'b0;
    if (reset_n) begin
      if (alg_starve || host_starve) begin
        if (alg_starve && host_starve) begin
          alg_gnt_d  = rr_alg_q;
          host_gnt_d = ~rr_alg_q;
        end else begin
          alg_gnt_d  = alg_starve;
          host_gnt_d = host_starve;
        end
      end else if (vga_req) begin
        vga_gnt_d = 1'b1;
      end else if (alg_req && host_req) begin
        alg_gnt_d  = rr_alg_q;
        host_gnt_d = ~rr_alg_q;
      end else begin
        alg_gnt_d  = alg_req;
        host_gnt_d = host_req;
      end
    end
  end

  // Read address select. When no read is granted the address holds and no
  // tag is issued.
  always_comb begin
    tag_d     = TAG_NONE;
    rd_addr_d = mem_rdaddress_q;
    if (vga_gnt_d) begin
      tag_d     = TAG_VGA;
      rd_addr_d = vga_addr;
    end else if (alg_gnt_d) begin
      tag_d     = TAG_ALG;
      rd_addr_d = alg_addr;
    end else if (host_gnt_d) begin
      tag_d     = TAG_HOST;
      rd_addr_d = host_addr;
    end
  end

  // Write arbitration: host STORE always wins over the algorithm writer.
  assign host_wr_gnt_d = reset_n & host_wr_req;
  assign alg_wr_gnt_d  = reset_n & alg_wr_req & ~host_wr_req;

`ifdef STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] alg_wait_q, host_wait_q;
  logic [WAIT_W-1:0] alg_wait_d, host_wait_d;

  assign alg_starve  = alg_req  && (alg_wait_q  == WAIT_SAT);
  assign host_starve = host_req && (host_wait_q == WAIT_SAT);
  assign vga_miss    = reset_n && vga_req && (alg_starve || host_starve);

  // Each counter clears on its grant and otherwise climbs, saturating, for
  // every cycle its request waits.
  always_comb begin
    alg_wait_d  = alg_wait_q;
    host_wait_d = host_wait_q;
    if (alg_gnt_d) begin
      alg_wait_d = '0;
    end else if (alg_req && alg_wait_q != WAIT_SAT) begin
      alg_wait_d = alg_wait_q + 1'b1;
    end
    if (host_gnt_d) begin
      host_wait_d = '0;
    end else if (host_req && host_wait_q != WAIT_SAT) begin
      host_wait_d = host_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alg_wait_q  <= '0;
      host_wait_q <= '0;
    end else begin
      alg_wait_q  <= alg_wait_d;
      host_wait_q <= host_wait_d;
    end
  end
`else
  assign alg_starve  = 1'b0;
  assign host_starve = 1'b0;
  assign vga_miss    = 1'b0;
`endif

  // Tag pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q[0] <= TAG_NONE;
    end else begin
      tag_q[0] <= tag_d;
    end
  end

  for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_tag_pipe
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        tag_q[gi] <= TAG_NONE;
      end else begin
        tag_q[gi] <= tag_q[gi-1];
      end
    end
  end

  for (genvar gi = 0; gi <= RD_LAT; gi++) begin : g_in_flight
    assign in_flight[gi] = (tag_q[gi] != TAG_NONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_alg_q        <= 1'b1;
      mem_rdaddress_q <= '0;
      mem_wraddress_q <= '0;
      mem_data_q      <= '0;
      mem_wren_q      <= 1'b0;
      vga_rvalid_q    <= 1'b0;
      alg_rvalid_q    <= 1'b0;
      host_rvalid_q   <= 1'b0;
      vga_rdata_q     <= '0;
      alg_rdata_q     <= '0;
      host_rdata_q    <= '0;
    end else begin
      mem_rdaddress_q <= rd_addr_d;

      if (alg_gnt_d) begin
        rr_alg_q <= 1'b0;
      end else if (host_gnt_d) begin
        rr_alg_q <= 1'b1;
      end

      mem_wren_q <= host_wr_gnt_d | alg_wr_gnt_d;
      if (host_wr_gnt_d) begin
        mem_wraddress_q <= host_wr_addr;
        mem_data_q      <= host_wr_data;
      end else if (alg_wr_gnt_d) begin
        mem_wraddress_q <= alg_wr_addr;
        mem_data_q      <= alg_wr_data;
      end

      // Only the tagged requester's rdata register loads; the others hold.
      vga_rvalid_q  <= (tag_q[RD_LAT] == TAG_VGA);
      alg_rvalid_q  <= (tag_q[RD_LAT] == TAG_ALG);
      host_rvalid_q <= (tag_q[RD_LAT] == TAG_HOST);
      if (tag_q[RD_LAT] == TAG_VGA)  vga_rdata_q  <= mem_q;
      if (tag_q[RD_LAT] == TAG_ALG)  alg_rdata_q  <= mem_q;
      if (tag_q[RD_LAT] == TAG_HOST) host_rdata_q <= mem_q;
    end
  end

  assign vga_gnt       = vga_gnt_d;
  assign alg_gnt       = alg_gnt_d;
  assign host_gnt      = host_gnt_d;
  assign alg_wr_gnt    = alg_wr_gnt_d;
  assign host_wr_gnt   = host_wr_gnt_d;
  assign vga_rvalid    = vga_rvalid_q;
  assign alg_rvalid    = alg_rvalid_q;
  assign host_rvalid   = host_rvalid_q;
  assign vga_rdata     = vga_rdata_q;
  assign alg_rdata     = alg_rdata_q;
  assign host_rdata    = host_rdata_q;
  assign mem_rdaddress = mem_rdaddress_q;
  assign mem_wraddress = mem_wraddress_q;
  assign mem_data      = mem_data_q;
  assign mem_wren      = mem_wren_q;
  assign busy          = (|in_flight) | mem_wren_q;

endmodule
